// File: rtl/ha_serial_sequencer_if.sv
// Operand/result handshake bundle for ha_serial_sequencer.
// The sub field exists only when HA_SEQ_SUB_EN is defined.
interface ha_serial_sequencer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef HA_SEQ_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

`ifdef HA_SEQ_SUB_EN
  modport master (output start, a, b, sub, input sum, cout, busy, done);
  modport slave  (input start, a, b, sub, output sum, cout, busy, done);
`else
  modport master (output start, a, b, input sum, cout, busy, done);
  modport slave  (input start, a, b, output sum, cout, busy, done);
`endif
endinterface

// File: rtl/ha_serial_sequencer.sv
// Bit-serial adder that time-shares one external half-adder, two passes per bit.
// Define HA_SEQ_SUB_EN to add a subtract mode (bus.sub) via ~b and carry-in 1.
module ha_serial_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  ha_serial_sequencer_if.slave  bus,
  output logic                  ha_a,
  output logic                  ha_b,
  input  logic                  ha_s,
  input  logic                  ha_c
);
  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HA1  = 2'd1;
  localparam logic [1:0] HA2  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             cy;
  logic             s1;
  logic             c1;
  logic             carry_in;
  logic             last_bit;

`ifdef HA_SEQ_SUB_EN
  logic sub_r;
  assign b_eff    = sub_r ? ~b_r : b_r;
  assign carry_in = bus.sub;
`else
  assign b_eff    = b_r;
  assign carry_in = 1'b0;
`endif

  assign last_bit = (idx == IDXW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      cy     <= 1'b0;
      s1     <= 1'b0;
      c1     <= 1'b0;
`ifdef HA_SEQ_SUB_EN
      sub_r  <= 1'b0;
`endif
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
`ifdef HA_SEQ_SUB_EN
            sub_r <= bus.sub;
`endif
            idx   <= '0;
            cy    <= carry_in;
            sum_r <= '0;
            state <= HA1;
          end
        end
        HA1: begin
          s1    <= ha_s;
          c1    <= ha_c;
          state <= HA2;
        end
        HA2: begin
          sum_r[idx] <= ha_s;
          cy         <= c1 | ha_c;
          if (last_bit) begin
            cout_r <= c1 | ha_c;
            state  <= DONE;
          end else begin
            idx   <= idx + IDXW'(1);
            state <= HA1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // HA drive is a pure decode of registered state, so a stalled FSM keeps it steady.
  always_comb begin
    ha_a = 1'b0;
    ha_b = 1'b0;
    case (state)
      HA1: begin
        ha_a = a_r[idx];
        ha_b = b_eff[idx];
      end
      HA2: begin
        ha_a = s1;
        ha_b = cy;
      end
      default: ;
    endcase
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.busy = (state == HA1) || (state == HA2);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_ha_serial_sequencer.sv
// Directed self-checking bench for ha_serial_sequencer with a behavioural half-adder.
module tb_ha_serial_sequencer;
  logic clk;
  logic rst_n;
  logic ena;
  logic ha_a, ha_b, ha_s, ha_c;
  int   total;
  int   bad;

  ha_serial_sequencer_if #(.WIDTH(8)) bus ();

`ifdef HA_SEQ_SUB_EN
  logic sub_sel;
  assign bus.sub = sub_sel;
`endif

  ha_serial_sequencer #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus),
    .ha_a  (ha_a),
    .ha_b  (ha_b),
    .ha_s  (ha_s),
    .ha_c  (ha_c)
  );

  assign ha_s = ha_a ^ ha_b;
  assign ha_c = ha_a & ha_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the caller at the negedge following E0 (k = 0).
  task automatic start_op(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Steps negedge by negedge from k0 until done; lat = -1 if the budget runs out.
  task automatic wait_done(input int k0, input int b0, output int lat, output int bc);
    lat = -1;
    bc  = b0;
    for (int k = k0; k < 80; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    total++; if (bus.sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", bus.cout); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if ({ha_a, ha_b} !== 2'b00) begin bad++; $display("FAIL reset_ha got=%b want=00", {ha_a, ha_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_no_start_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_basic_add;
    int lat, bc, b0;
    start_op(8'h3C, 8'h05);
    // k=0: HA1 on bit0 (a=0, b=1); k=1: HA2 with s1=1, cy=0
    total++; if ({ha_a, ha_b} !== 2'b01) begin bad++; $display("FAIL ha1_drive got=%b want=01", {ha_a, ha_b}); end
    b0 = (bus.busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    total++; if ({ha_a, ha_b} !== 2'b10) begin bad++; $display("FAIL ha2_drive got=%b want=10", {ha_a, ha_b}); end
    wait_done(1, b0, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", lat); end
    total++; if (bc !== 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=16", bc); end
    total++; if (bus.sum !== 8'h41) begin bad++; $display("FAIL basic_sum got=%h want=41", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", bus.cout); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", bus.done); end
    repeat (3) @(negedge clk);
    total++; if (bus.sum !== 8'h41) begin bad++; $display("FAIL sum_hold got=%h want=41", bus.sum); end
    total++; if ({ha_a, ha_b} !== 2'b00) begin bad++; $display("FAIL idle_ha got=%b want=00", {ha_a, ha_b}); end
  endtask

  task automatic test_wrap;
    int lat, bc;
    start_op(8'hFF, 8'h01);
    wait_done(0, 0, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL wrap_latency got=%0d want=16", lat); end
    total++; if (bus.sum !== 8'h00) begin bad++; $display("FAIL wrap_sum got=%h want=00", bus.sum); end
    total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL wrap_cout got=%b want=1", bus.cout); end
    start_op(8'h00, 8'h00);
    wait_done(0, 0, lat, bc);
    total++; if (bus.sum !== 8'h00) begin bad++; $display("FAIL zero_sum got=%h want=00", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL zero_cout got=%b want=0", bus.cout); end
  endtask

  task automatic test_ignored_start;
    int lat, bc;
    start_op(8'h12, 8'h34);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5, 0, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL busy_start_latency got=%0d want=16", lat); end
    total++; if (bus.sum !== 8'h46) begin bad++; $display("FAIL busy_start_sum got=%h want=46", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL busy_start_cout got=%b want=0", bus.cout); end
    // start presented during DONE must not launch an operation
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL done_start_busy got=%b want=0", bus.busy); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL done_start_busy2 got=%b want=0", bus.busy); end
    total++; if (bus.sum !== 8'h46) begin bad++; $display("FAIL done_start_sum got=%h want=46", bus.sum); end
  endtask

  task automatic test_ena_stall;
    int lat, bc;
    logic [1:0] ha_snap;
    start_op(8'h80, 8'h80);
    repeat (5) @(negedge clk);
    ha_snap = {ha_a, ha_b};
    ena = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b want=1", bus.busy); end
    total++; if ({ha_a, ha_b} !== ha_snap) begin bad++; $display("FAIL stall_ha got=%b want=%b", {ha_a, ha_b}, ha_snap); end
    repeat (2) @(negedge clk);
    ena = 1'b1;
    wait_done(8, 0, lat, bc);
    total++; if (lat !== 19) begin bad++; $display("FAIL stall_latency got=%0d want=19", lat); end
    total++; if (bus.sum !== 8'h00) begin bad++; $display("FAIL stall_sum got=%h want=00", bus.sum); end
    total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL stall_cout got=%b want=1", bus.cout); end
    ena = 1'b0;
    @(negedge clk);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL done_stalled got=%b want=1", bus.done); end
    ena = 1'b1;
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_released got=%b want=0", bus.done); end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    start_op(8'hAA, 8'h55);
    repeat (6) @(negedge clk);
    total++; if (bus.sum !== 8'h07) begin bad++; $display("FAIL partial_sum got=%h want=07", bus.sum); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.sum !== 8'h00) begin bad++; $display("FAIL midrst_sum got=%h want=00", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL midrst_cout got=%b want=0", bus.cout); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    total++; if ({ha_a, ha_b} !== 2'b00) begin bad++; $display("FAIL midrst_ha got=%b want=00", {ha_a, ha_b}); end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h01, 8'h02);
    wait_done(0, 0, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL post_rst_latency got=%0d want=16", lat); end
    total++; if (bus.sum !== 8'h03) begin bad++; $display("FAIL post_rst_sum got=%h want=03", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL post_rst_cout got=%b want=0", bus.cout); end
  endtask

`ifdef HA_SEQ_SUB_EN
  task automatic test_sub;
    int lat, bc;
    sub_sel = 1'b1;
    start_op(8'h10, 8'h01);
    wait_done(0, 0, lat, bc);
    total++; if (bus.sum !== 8'h0F) begin bad++; $display("FAIL sub_sum1 got=%h want=0f", bus.sum); end
    total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL sub_cout1 got=%b want=1", bus.cout); end
    start_op(8'h01, 8'h02);
    wait_done(0, 0, lat, bc);
    total++; if (bus.sum !== 8'hFF) begin bad++; $display("FAIL sub_sum2 got=%h want=ff", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL sub_cout2 got=%b want=0", bus.cout); end
    sub_sel = 1'b0;
    start_op(8'h10, 8'h01);
    wait_done(0, 0, lat, bc);
    total++; if (bus.sum !== 8'h11) begin bad++; $display("FAIL sub0_sum got=%h want=11", bus.sum); end
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef HA_SEQ_SUB_EN
    sub_sel   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset;
    test_basic_add;
    test_wrap;
    test_ignored_start;
    test_ena_stall;
    test_reset_mid;
`ifdef HA_SEQ_SUB_EN
    test_sub;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
